// File: rtl/uart_mitm_pkg.sv
// Shared types and default constants for the UART man-in-the-middle transmit scheduler.
package uart_mitm_pkg;

  typedef enum logic [1:0] {
    MODE_FWD = 2'd0,
    MODE_OVR = 2'd1,
    MODE_MIX = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  typedef enum logic {
    SRC_FWD = 1'b0,
    SRC_PC  = 1'b1
  } src_e;

  localparam logic [7:0] DEF_CMD_OVERRIDE = 8'h65;
  localparam logic [7:0] DEF_CMD_FORWARD  = 8'h64;
  localparam logic [7:0] DEF_CMD_MIX      = 8'h6D;
  localparam int         DEF_BUSY_TIMEOUT = 3;

endpackage

// File: rtl/uart_hold_buf.sv
// One-byte holding register with full flag; reports captures it cannot take as drops.
module uart_hold_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       issuing,
  input  logic       flush,
  output logic [7:0] data,
  output logic       full,
  output logic       drop
);

  logic capture;

  // A slot being issued this cycle frees up in time to accept a new byte.
  always_comb begin
    capture = strobe && enable && (!full || issuing) && !flush;
    drop    = strobe && enable && full && !issuing;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= 8'h00;
      full <= 1'b0;
    end else if (capture) begin
      data <= data_in;
      full <= 1'b1;
    end else if (flush || issuing) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules forward-path and PC bytes onto one shared UART transmitter under a
// PC-selected mode (forward, override, mix), counting bytes lost to full buffers.
module uart_tx_sched
  import uart_mitm_pkg::*;
#(
  parameter logic [7:0] CMD_OVERRIDE = DEF_CMD_OVERRIDE,
  parameter logic [7:0] CMD_FORWARD  = DEF_CMD_FORWARD,
  parameter logic [7:0] CMD_MIX      = DEF_CMD_MIX,
  parameter int         BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fwd_valid,
  input  logic [7:0] fwd_data,
  input  logic       pc_valid,
  input  logic [7:0] pc_data,
  input  logic       tx_rdy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic [1:0] mode,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  mode_e       mode_q;
  mode_e       cmd_mode;
  state_e      state;
  src_e        grant;
  src_e        last_grant;
  src_e        pick;
  logic [7:0]  wait_cnt;
  logic        pc_is_cmd;
  logic        mode_change;
  logic        fwd_en, pc_en;
  logic        fwd_full, pc_full;
  logic [7:0]  fwd_q, pc_q;
  logic        fwd_drop, pc_drop;
  logic        fwd_elig, pc_elig;
  logic        fwd_issuing, pc_issuing;
  logic [8:0]  drop_sum;

  always_comb begin
    pc_is_cmd = 1'b0;
    cmd_mode  = mode_q;
    if (pc_valid) begin
      if (pc_data == CMD_OVERRIDE) begin
        pc_is_cmd = 1'b1;
        cmd_mode  = MODE_OVR;
      end else if (pc_data == CMD_FORWARD) begin
        pc_is_cmd = 1'b1;
        cmd_mode  = MODE_FWD;
      end else if (pc_data == CMD_MIX) begin
        pc_is_cmd = 1'b1;
        cmd_mode  = MODE_MIX;
      end
    end
  end

  assign mode_change = pc_is_cmd && (cmd_mode != mode_q);
  assign fwd_en      = (mode_q != MODE_OVR);
  assign pc_en       = (mode_q != MODE_FWD);
  assign fwd_issuing = (state == ST_ISSUE) && (grant == SRC_FWD);
  assign pc_issuing  = (state == ST_ISSUE) && (grant == SRC_PC);

  uart_hold_buf u_fwd_buf (
    .clk     (clk),
    .rst     (rst),
    .strobe  (fwd_valid),
    .data_in (fwd_data),
    .enable  (fwd_en),
    .issuing (fwd_issuing),
    .flush   (mode_change && (cmd_mode == MODE_OVR)),
    .data    (fwd_q),
    .full    (fwd_full),
    .drop    (fwd_drop)
  );

  // Command bytes steer the mode only; they never reach the PC buffer.
  uart_hold_buf u_pc_buf (
    .clk     (clk),
    .rst     (rst),
    .strobe  (pc_valid && !pc_is_cmd),
    .data_in (pc_data),
    .enable  (pc_en),
    .issuing (pc_issuing),
    .flush   (mode_change && (cmd_mode == MODE_FWD)),
    .data    (pc_q),
    .full    (pc_full),
    .drop    (pc_drop)
  );

  assign fwd_elig = fwd_full && fwd_en;
  assign pc_elig  = pc_full && pc_en;

  always_comb begin
    pick = SRC_FWD;
    if (fwd_elig && pc_elig) begin
      pick = (last_grant == SRC_FWD) ? SRC_PC : SRC_FWD;
    end else if (pc_elig) begin
      pick = SRC_PC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_FWD;
    end else if (pc_is_cmd) begin
      mode_q <= cmd_mode;
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + {8'h00, fwd_drop} + {8'h00, pc_drop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= 8'h00;
    end else if (drop_sum > 9'd255) begin
      drop_cnt <= 8'hFF;
    end else begin
      drop_cnt <= drop_sum[7:0];
    end
  end

  // tx_en/tx_data are registered on entry to ISSUE, so they line up with that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      grant      <= SRC_FWD;
      last_grant <= SRC_PC;
      wait_cnt   <= 8'h00;
      tx_en      <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
      case (state)
        ST_IDLE: begin
          if (tx_rdy && (fwd_elig || pc_elig)) begin
            state   <= ST_ISSUE;
            grant   <= pick;
            tx_en   <= 1'b1;
            tx_data <= (pick == SRC_FWD) ? fwd_q : pc_q;
          end
        end
        ST_ISSUE: begin
          last_grant <= grant;
          wait_cnt   <= 8'h00;
          state      <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!tx_rdy) begin
            state <= ST_WAIT_DONE;
          end else if (wait_cnt == 8'(BUSY_TIMEOUT - 1)) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'h01;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_rdy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mode = mode_q;
  assign busy = (state != ST_IDLE) || fwd_full || pc_full;

endmodule
